// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared types and default widths for the ADC capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

   localparam int C_DATA_W   = 16;
   localparam int C_CNT_W    = 16;
   localparam int C_PERIOD_W = 16;
   localparam int C_TIMEOUT  = 255;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_GAP       = 3'd3,
      ST_DRAIN     = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_if
// Description : AXI4-Stream sample channel between the sequencer and its sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_seq_if
   import adc_seq_pkg::*;
#(
   parameter int DATA_W = C_DATA_W
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/adc_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_timer
// Description : Loadable down-counter that stops at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_seq_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q;

   // Load has priority; otherwise count down and hold at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_sequencer
// Description : Issues ADC convert-start pulses at a programmed period, waits
//               for each result and forwards it on an AXI4-Stream master.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_sequencer
   import adc_seq_pkg::*;
#(
   parameter int DATA_W   = C_DATA_W,
   parameter int CNT_W    = C_CNT_W,
   parameter int PERIOD_W = C_PERIOD_W,
   parameter int TIMEOUT  = C_TIMEOUT
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                cfg_start,
   input  logic                cfg_abort,
   input  logic [CNT_W-1:0]    cfg_num_samples,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic                adc_convst,
   input  logic                adc_data_valid,
   input  logic [DATA_W-1:0]   adc_data,
   adc_seq_if.master           m_axis,
   output logic                sts_busy,
   output logic                sts_done,
   output logic                sts_overrun,
   output logic                sts_timeout,
   output logic [CNT_W-1:0]    sts_count
);
   // Timeout timer is loaded with TIMEOUT-1 in the convst cycle so the flag
   // becomes visible exactly TIMEOUT cycles after the convst pulse.
   localparam int              TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

   state_t              state_q;
   logic [CNT_W-1:0]    num_q;
   logic [CNT_W-1:0]    count_q;
   logic [PERIOD_W-1:0] period_q;
   logic                convst_q;
   logic                busy_q;
   logic                done_q;
   logic                overrun_q;
   logic                timeout_q;
   logic [DATA_W-1:0]   tdata_q;
   logic                tvalid_q;
   logic                tlast_q;

   logic                axis_hs;
   logic                start_ok;
   logic                capture;
   logic                is_last;
   logic                to_trig;
   logic                per_zero;
   logic                tmo_zero;
   logic [CNT_W-1:0]    count_inc;
   logic [PERIOD_W-1:0] per_src;
   logic [PERIOD_W-1:0] per_load;

   assign axis_hs   = tvalid_q & m_axis.tready;
   assign start_ok  = (state_q == ST_IDLE) & cfg_start & ~cfg_abort & (cfg_num_samples != '0);
   assign capture   = (state_q == ST_WAIT_DATA) & adc_data_valid & ~cfg_abort;
   assign count_inc = count_q + CNT_W'(1);
   assign is_last   = (count_inc == num_q);

   // Timers are (re)loaded on the edge that enters TRIG, so they run from the
   // convst cycle. A capture that finds the period already expired goes
   // straight back to TRIG, giving convst the cycle after the data strobe.
   assign to_trig = start_ok
                  | (capture & ~is_last & per_zero)
                  | ((state_q == ST_GAP) & per_zero & ~cfg_abort);

   // Period 0 and 1 both mean one cycle; load value is the period minus one.
   assign per_src  = (state_q == ST_IDLE) ? cfg_period : period_q;
   assign per_load = (per_src > PERIOD_W'(1)) ? (per_src - PERIOD_W'(1)) : '0;

   adc_seq_timer #(.W(PERIOD_W)) u_period_timer (
      .clk        (ACLK),
      .rst        (ARESET),
      .load_i     (to_trig),
      .load_val_i (per_load),
      .zero_o     (per_zero)
   );

   adc_seq_timer #(.W(TMO_W)) u_timeout_timer (
      .clk        (ACLK),
      .rst        (ARESET),
      .load_i     (to_trig),
      .load_val_i (TMO_LOAD),
      .zero_o     (tmo_zero)
   );

   // Sequencer FSM with registered convst, AXIS beat and status outputs.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         count_q   <= '0;
         period_q  <= '0;
         convst_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
      end else begin
         convst_q <= to_trig;
         if (axis_hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end
         if (cfg_abort) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cfg_start) begin
                     count_q   <= '0;
                     overrun_q <= 1'b0;
                     timeout_q <= 1'b0;
                     if (cfg_num_samples != '0) begin
                        num_q    <= cfg_num_samples;
                        period_q <= cfg_period;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_TRIG;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               ST_TRIG: begin
                  state_q <= ST_WAIT_DATA;
               end
               ST_WAIT_DATA: begin
                  if (adc_data_valid) begin
                     count_q <= count_inc;
                     // Output register still holds an unaccepted beat: drop.
                     if (tvalid_q && !m_axis.tready) begin
                        overrun_q <= 1'b1;
                     end else begin
                        tdata_q  <= adc_data;
                        tvalid_q <= 1'b1;
                        tlast_q  <= is_last;
                     end
                     if (is_last) begin
                        state_q <= ST_DRAIN;
                     end else if (per_zero) begin
                        state_q <= ST_TRIG;
                     end else begin
                        state_q <= ST_GAP;
                     end
                  end else if (tmo_zero) begin
                     timeout_q <= 1'b1;
                     busy_q    <= 1'b0;
                     tvalid_q  <= 1'b0;
                     tlast_q   <= 1'b0;
                     state_q   <= ST_IDLE;
                  end
               end
               ST_GAP: begin
                  if (per_zero) begin
                     state_q <= ST_TRIG;
                  end
               end
               ST_DRAIN: begin
                  if (!tvalid_q || m_axis.tready) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign adc_convst    = convst_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign sts_busy      = busy_q;
   assign sts_done      = done_q;
   assign sts_overrun   = overrun_q;
   assign sts_timeout   = timeout_q;
   assign sts_count     = count_q;
endmodule
`default_nettype wire
